// File: rtl/branch_resolve_pkg.sv
// Shared types for the EX-stage branch resolver: predictor source encoding,
// branch funct3 codes and the BTB training record.
package branch_resolve_pkg;

    localparam int BRU_XLEN = 32;

    typedef enum logic [1:0] {
        PRED_NONE = 2'd0,
        PRED_BTB  = 2'd1,
        PRED_RAS  = 2'd2
    } pred_source_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [BRU_XLEN-1:0] pc;
        logic [BRU_XLEN-1:0] target;
        logic                taken;
    } btb_update_t;

    // Undefined funct3 encodings resolve not taken.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic [BRU_XLEN-1:0] a,
                                          input logic [BRU_XLEN-1:0] b);
        logic result;
        result = 1'b0;
        case (funct3)
            F3_BEQ:  result = (a == b);
            F3_BNE:  result = (a != b);
            F3_BLT:  result = ($signed(a) < $signed(b));
            F3_BGE:  result = ($signed(a) >= $signed(b));
            F3_BLTU: result = (a < b);
            F3_BGEU: result = (a >= b);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/branch_update_fifo.sv
// Small circular FIFO of BTB training records; pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
module branch_update_fifo
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_valid,
    input  btb_update_t push_data,
    input  logic        pop_ready,
    output logic        full,
    output logic        empty,
    output btb_update_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    btb_update_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push_valid && !full;
    assign do_pop  = pop_ready && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage resolver for branches, JAL and JALR: registered redirect on
// mispredict and a queue of predictor-training updates for the BTB.
module branch_resolve_unit
    import branch_resolve_pkg::*;
#(
    parameter int XLEN      = BRU_XLEN,
    parameter int UPD_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic            i_flush,
    input  logic            i_is_branch,
    input  logic            i_is_jal,
    input  logic            i_is_jalr,
    input  logic [2:0]      i_branch_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_program_counter,
    input  logic [XLEN-1:0] i_immediate_i_type,
    input  logic [XLEN-1:0] i_branch_target_precomputed,
    input  logic [XLEN-1:0] i_jal_target_precomputed,
    input  logic [XLEN-1:0] i_ras_expected_rs1,
    input  logic [XLEN-1:0] i_btb_expected_rs1,
    input  logic            i_btb_correct_non_jalr,
    input  logic            i_pred_taken,
    input  logic [1:0]      i_pred_source,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_stall_req,
    output logic            o_upd_valid,
    input  logic            i_upd_ready,
    output logic [XLEN-1:0] o_upd_pc,
    output logic [XLEN-1:0] o_upd_target,
    output logic            o_upd_taken,
    output logic [31:0]     o_resolved_count,
    output logic [31:0]     o_mispredict_count
);

    pred_source_e    pred_src;
    logic            accept;
    logic            taken;
    logic            mispredict;
    logic            needs_push;
    logic            jalr_ok;
    logic            fifo_full;
    logic            fifo_empty;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] actual_target;
    btb_update_t     push_entry;
    btb_update_t     head_entry;

    assign pred_src    = pred_source_e'(i_pred_source);
    assign pc_plus4    = i_program_counter + XLEN'(4);
    assign jalr_target = (i_rs1 + i_immediate_i_type) & ~XLEN'(1);

    // Expected-rs1 compare avoids an adder on the critical path; an odd rs1+imm
    // can therefore flag a mispredict that the redirect then makes harmless.
    assign jalr_ok = i_pred_taken &&
                     (((pred_src == PRED_RAS) && (i_rs1 == i_ras_expected_rs1)) ||
                      ((pred_src == PRED_BTB) && (i_rs1 == i_btb_expected_rs1)));

    always_comb begin
        taken         = 1'b0;
        mispredict    = i_pred_taken;
        actual_target = pc_plus4;
        needs_push    = 1'b1;
        if (i_is_branch) begin
            taken         = branch_taken(i_branch_funct3, i_rs1, i_rs2);
            mispredict    = (taken != i_pred_taken) ||
                            (taken && (pred_src == PRED_BTB) && !i_btb_correct_non_jalr);
            actual_target = taken ? i_branch_target_precomputed : pc_plus4;
        end else if (i_is_jal) begin
            taken         = 1'b1;
            mispredict    = !i_pred_taken ||
                            ((pred_src == PRED_BTB) && !i_btb_correct_non_jalr);
            actual_target = i_jal_target_precomputed;
        end else if (i_is_jalr) begin
            taken         = 1'b1;
            mispredict    = !jalr_ok;
            actual_target = jalr_target;
            needs_push    = !((pred_src == PRED_RAS) && jalr_ok);
        end
    end

    // No pop bypass: a full FIFO stalls even when the BTB drains it this cycle.
    assign o_stall_req = i_valid && !i_flush && !o_redirect_valid && needs_push && fifo_full;
    assign accept      = i_valid && !i_flush && !o_redirect_valid && !o_stall_req;
    assign push_entry  = {i_program_counter, actual_target, taken};

    // Update handshake: the head entry transfers on a cycle where o_upd_valid and
    // i_upd_ready are both high; valid and head fields stay stable until then.
    branch_update_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_update_fifo (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .push_valid (accept && needs_push),
        .push_data  (push_entry),
        .pop_ready  (i_upd_ready),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head_entry)
    );

    assign o_upd_valid  = !fifo_empty;
    assign o_upd_pc     = head_entry.pc;
    assign o_upd_target = head_entry.target;
    assign o_upd_taken  = head_entry.taken;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_redirect_valid   <= 1'b0;
            o_redirect_pc      <= '0;
            o_resolved_count   <= '0;
            o_mispredict_count <= '0;
        end else begin
            o_redirect_valid <= accept && mispredict;
            if (accept && mispredict) begin
                o_redirect_pc <= actual_target;
            end
            if (accept) begin
                o_resolved_count <= o_resolved_count + 32'd1;
                if (mispredict) begin
                    o_mispredict_count <= o_mispredict_count + 32'd1;
                end
            end
        end
    end

endmodule
